// File: rtl/mipi_payload_framer.sv
`default_nettype none
// ============================================================================
// Module   : mipi_payload_framer
// Purpose  : Captures a DLEN-byte payload and streams it as framed 48-bit
//            pixel words: sync marker, header, zero-padded data words and an
//            XOR checksum. One word per active pixel cycle, repeated across
//            REPEATS video frames.
// Revision : 1.0 - initial release
// ============================================================================
module mipi_payload_framer #(
  parameter int DLEN    = 512,
  parameter int REPEATS = 1
) (
  input  logic              tx_pixel_clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DLEN*8-1:0] payload,
  input  logic              frame_start,
  input  logic              pixel_req,
  output logic [63:0]       pixel_value,
  output logic              busy,
  output logic              done
);

  // Data words per packet, total words per packet, index width
  localparam int N   = (DLEN + 5) / 6;
  localparam int NW  = N + 3;
  localparam int IW  = (NW > 1) ? $clog2(NW) : 1;
  localparam int PW  = N * 48;

  localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);
  localparam logic [47:0]   MARKER   = 48'h7E7E7E7E7E7E;
  localparam logic [47:0]   HEADER   = {16'hC0DE, 16'h0000, 16'(DLEN)};
  localparam logic [7:0]    REP_LAST = 8'(REPEATS - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ARMED      = 2'd1,
    SEND       = 2'd2,
    WAIT_FRAME = 2'd3
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [7:0]      rep_cnt;
  logic [47:0]     csum;
  logic [PW-1:0]   payload_r;
  logic [PW-1:0]   padded;
  logic [47:0]     data_word;
  logic [47:0]     cur_word;
  logic            is_data;

  // Zero-extend the payload to a whole number of 6-byte words
  always_comb begin
    padded                = '0;
    padded[DLEN*8-1:0]    = payload;
  end

  // Select the data word addressed by the current index (indices 2..N+1)
  always_comb begin
    data_word = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == IW'(k + 2)) begin
        data_word = payload_r[k*48 +: 48];
      end
    end
  end

  // Map the word index onto marker / header / data / checksum
  always_comb begin
    is_data = 1'b0;
    if (idx == '0) begin
      cur_word = MARKER;
    end else if (idx == IW'(1)) begin
      cur_word = HEADER;
    end else if (idx == LAST_IDX) begin
      cur_word = csum;
    end else begin
      cur_word = data_word;
      is_data  = 1'b1;
    end
  end

  // Word is presented with zero latency; only visible while sending
  always_comb begin
    pixel_value = (state == SEND) ? {16'h0000, cur_word} : 64'h0;
  end

  // Packet sequencing: capture, arm, send, wait for next frame, finish
  always_ff @(posedge tx_pixel_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      rep_cnt   <= '0;
      csum      <= '0;
      payload_r <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A coincident frame_start is deliberately not acted on here
          if (load) begin
            payload_r <= padded;
            rep_cnt   <= '0;
            busy      <= 1'b1;
            state     <= ARMED;
          end
        end
        ARMED, WAIT_FRAME: begin
          if (frame_start) begin
            idx   <= '0;
            csum  <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (frame_start) begin
            // New frame before the packet finished: restart from the marker
            idx  <= '0;
            csum <= '0;
          end else if (pixel_req) begin
            if (idx == LAST_IDX) begin
              idx     <= '0;
              rep_cnt <= rep_cnt + 8'd1;
              if (rep_cnt == REP_LAST) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= IDLE;
              end else begin
                state <= WAIT_FRAME;
              end
            end else begin
              idx <= idx + IW'(1);
              if (is_data) begin
                csum <= csum ^ data_word;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mipi_payload_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mipi_payload_framer
// Purpose  : Self-checking bench for mipi_payload_framer. Two instances
//            (DLEN=6/REPEATS=1 and DLEN=7/REPEATS=2) share control inputs and
//            are compared every cycle against a packet-level model, plus
//            directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mipi_payload_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        frame_start = 1'b0;
  logic        pixel_req = 1'b0;
  logic [47:0] pay_a = '0;
  logic [55:0] pay_b = '0;
  logic [63:0] pv_a, pv_b;
  logic        busy_a, busy_b, done_a, done_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mipi_payload_framer #(.DLEN(6), .REPEATS(1)) u_a (
    .tx_pixel_clk(clk), .rst(rst), .load(load), .payload(pay_a),
    .frame_start(frame_start), .pixel_req(pixel_req),
    .pixel_value(pv_a), .busy(busy_a), .done(done_a)
  );

  mipi_payload_framer #(.DLEN(7), .REPEATS(2)) u_b (
    .tx_pixel_clk(clk), .rst(rst), .load(load), .payload(pay_b),
    .frame_start(frame_start), .pixel_req(pixel_req),
    .pixel_value(pv_b), .busy(busy_b), .done(done_b)
  );

  // ---------------- packet-level model ----------------
  // Each instance: list of expected words, position in it (-1 = not sending),
  // completed repeats, expected busy/done.
  logic [47:0] mw [2][8];
  int          mn [2];
  int          mpos [2]  = '{-1, -1};
  int          mreps [2] = '{0, 0};
  bit          mbusy [2] = '{0, 0};
  bit          mdone [2] = '{0, 0};
  int          mdlen [2] = '{6, 7};
  int          mrepeat [2] = '{1, 2};

  task automatic build(input int d, input logic [55:0] p);
    int n;
    logic [47:0] w, cs;
    n  = (mdlen[d] + 5) / 6;
    cs = '0;
    mw[d][0] = 48'h7E7E7E7E7E7E;
    mw[d][1] = {16'hC0DE, 16'h0000, 16'(mdlen[d])};
    for (int k = 0; k < n; k++) begin
      w = '0;
      for (int j = 0; j < 6; j++) begin
        if (6*k + j < mdlen[d]) w[8*j +: 8] = p[8*(6*k+j) +: 8];
      end
      mw[d][2+k] = w;
      cs = cs ^ w;
    end
    mw[d][n+2] = cs;
    mn[d] = n + 3;
  endtask

  // Model advances on each clock edge using the inputs held across it
  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mpos[d] = -1; mreps[d] = 0; mbusy[d] = 0; mdone[d] = 0;
      end else begin
        mdone[d] = 0;
        if (!mbusy[d]) begin
          if (load) begin
            build(d, (d == 0) ? {8'h00, pay_a} : pay_b);
            mbusy[d] = 1; mpos[d] = -1; mreps[d] = 0;
          end
        end else if (mpos[d] < 0) begin
          if (frame_start) mpos[d] = 0;
        end else if (frame_start) begin
          mpos[d] = 0;
        end else if (pixel_req) begin
          if (mpos[d] == mn[d] - 1) begin
            mreps[d]++;
            mpos[d] = -1;
            if (mreps[d] == mrepeat[d]) begin
              mbusy[d] = 0; mdone[d] = 1;
            end
          end else begin
            mpos[d]++;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    logic [63:0] e;
    for (int d = 0; d < 2; d++) begin
      e = (mbusy[d] && mpos[d] >= 0) ? {16'h0, mw[d][mpos[d]]} : 64'h0;
      check(d == 0 ? "model_pv_a" : "model_pv_b", d == 0 ? pv_a : pv_b, e);
      check(d == 0 ? "model_busy_a" : "model_busy_b",
            64'(d == 0 ? busy_a : busy_b), 64'(mbusy[d]));
      check(d == 0 ? "model_done_a" : "model_done_b",
            64'(d == 0 ? done_a : done_b), 64'(mdone[d]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input bit ld, input bit fs, input bit pr);
    load = ld; frame_start = fs; pixel_req = pr;
    @(posedge clk); #2;
  endtask

  initial begin
    pay_a = 48'h665544332211;
    pay_b = 56'h77665544332211;
    @(posedge clk); #1;
    check("reset_pv_a", pv_a, 64'h0);
    check("reset_busy_a", 64'(busy_a), 64'h0);
    check("reset_done_b", 64'(done_b), 64'h0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Basic packet, DLEN=6 and DLEN=7 (padding)
    cyc(1, 0, 0);
    check("armed_busy_a", 64'(busy_a), 64'h1);
    check("armed_pv_a", pv_a, 64'h0);
    cyc(0, 1, 0);
    check("w0_a", pv_a, 64'h00007E7E7E7E7E7E);
    cyc(0, 0, 1);
    check("hdr_a", pv_a, 64'h0000C0DE00000006);
    check("hdr_b", pv_b, 64'h0000C0DE00000007);
    cyc(0, 0, 1);
    check("d0_a", pv_a, 64'h0000665544332211);
    check("d0_b", pv_b, 64'h0000665544332211);
    cyc(0, 0, 1);
    check("cs_a", pv_a, 64'h0000665544332211);
    check("d1_b", pv_b, 64'h0000000000000077);
    cyc(0, 0, 1);
    check("done_a", 64'(done_a), 64'h1);
    check("busy_fall_a", 64'(busy_a), 64'h0);
    check("cs_b", pv_b, 64'h0000665544332266);
    cyc(0, 0, 1);
    check("waitframe_pv_b", pv_b, 64'h0);
    check("waitframe_busy_b", 64'(busy_b), 64'h1);
    check("done_b_not_yet", 64'(done_b), 64'h0);

    // Second repeat for B with pixel_req gaps
    cyc(0, 1, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, (i % 2) == 0);
    check("rep2_busy_b", 64'(busy_b), 64'h0);

    // load with frame_start from IDLE: frame_start ignored
    pay_b = 56'h0123456789ABCD;
    cyc(1, 1, 0);
    check("ldfs_pv_a", pv_a, 64'h0);
    check("ldfs_busy_a", 64'(busy_a), 64'h1);
    // load while busy: ignored
    pay_a = 48'hAABBCCDDEEFF;
    pay_b = 56'hFFEEDDCCBBAA99;
    cyc(1, 0, 1);
    cyc(0, 0, 1);
    check("armed_ignores_req_a", pv_a, 64'h0);
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    check("pre_abort_b", pv_b, 64'h0000000000000001);
    // frame_start coinciding with a consuming pixel_req restarts at W0
    cyc(0, 1, 1);
    check("abort_w0_a", pv_a, 64'h00007E7E7E7E7E7E);
    check("abort_w0_b", pv_b, 64'h00007E7E7E7E7E7E);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    check("stable_payload_b", pv_b, 64'h000023456789ABCD);
    cyc(0, 0, 1);
    check("stable_cs_a", pv_a, 64'h0000665544332211);
    cyc(0, 0, 1);
    check("abort_done_a", 64'(done_a), 64'h1);
    check("abort_cs_b", pv_b, 64'h000023456789ABCC);
    // load during the done pulse is captured
    cyc(1, 0, 1);
    check("load_on_done_a", 64'(busy_a), 64'h1);
    check("abort_no_rep_inc_b", 64'(busy_b), 64'h1);
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    check("new_payload_a", pv_a, 64'h0000AABBCCDDEEFF);

    // Asynchronous reset mid-send
    #2 rst = 1'b1;
    #1;
    check("arst_busy_b", 64'(busy_b), 64'h0);
    check("arst_pv_b", pv_b, 64'h0);
    check("arst_pv_a", pv_a, 64'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    check("post_rst_pv_a", pv_a, 64'h0);
    check("post_rst_busy_b", 64'(busy_b), 64'h0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mipi_payload_framer.md
Name: mipi_payload_framer

Overview:
- Transmit-side counterpart of the MIPI RX packet assembler.
- Captures a DLEN-byte payload and slices it into 48-bit pixel words, with framing so the RX side can locate and check the packet.
- Words are framed by a sync marker, a header and a checksum.
- Sits between the payload source and the MIPI TX DATA bus. Advances one word per active pixel cycle from the video timing generator.

Parameters:
- DLEN, 512, payload length in bytes (1..65535).
- REPEATS, 1, number of consecutive video frames in which the packet is sent (1..255).

Ports:
- tx_pixel_clk  input  1  sole clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  request to capture payload; honoured only when busy=0.
- payload  input  DLEN*8  payload; byte i = payload[8i+7:8i].
- frame_start  input  1  one-cycle pulse at start of each video frame (from vsync edge).
- pixel_req  input  1  high on each active pixel cycle; consumes the current word.
- pixel_value  output  64  word to TX DATA; bits [63:48] always 0.
- busy  output  1  packet captured and not yet fully sent REPEATS times.
- done  output  1  one-cycle pulse after the last word of the last repeat is consumed.

Behaviour:
- Reset (async, rst=1):
  - State IDLE; repeat counter 0; word index 0; checksum 0; payload register 0.
  - Outputs: busy=0, done=0, pixel_value=0.
- Word count: N = ceil(DLEN/6). Packet = N+3 words, sent in this order:
  - W0 marker = 48'h7E7E7E7E7E7E.
  - W1 header = {16'hC0DE, 16'h0000, DLEN[15:0]}.
  - W2..W(N+1) data: data word k, bits [8j+7:8j] = byte 6k+j. Bytes beyond DLEN-1 are 0 (zero padding in the last word).
  - W(N+2) checksum = XOR of all N padded data words.
- pixel_value timing:
  - Combinational function of state and word index (zero latency): the word on pixel_value is the one consumed at a rising edge with pixel_req=1.
  - Index and checksum update on that edge.
  - pixel_value=0 in IDLE, ARMED and WAIT_FRAME.
- States:
  - IDLE: load=1 captures payload, sets repeat counter=0 and busy=1 on the next cycle, and goes to ARMED. A frame_start in the same cycle as load is ignored.
  - ARMED: frame_start=1 -> SEND with index=0 and checksum=0. pixel_req is ignored.
  - SEND: each pixel_req=1 cycle advances the index. After W(N+2) is consumed, increment the repeat counter. If the counter reaches REPEATS, go to IDLE, drop busy, and pulse done in the following cycle. Otherwise go to WAIT_FRAME.
  - WAIT_FRAME: frame_start=1 -> SEND with index=0 and checksum=0.
- Boundary conditions:
  - frame_start while in SEND (packet not finished in one frame): abort, restart at W0 in the new frame, checksum cleared, repeat counter unchanged.
  - frame_start and the consuming pixel_req on the same edge: frame_start wins (restart at W0).
  - pixel_req gaps (blanking) stall the index; no words are lost or duplicated.
  - load while busy=1 is ignored; the payload register stays stable.
  - load in the cycle done pulses: busy=0, so it is captured.
  - Checksum is accumulated from the words actually emitted. It must equal the precomputed XOR; either implementation is acceptable if the emitted values match.
  - Index counter width is clog2(N+3). It must not wrap inside a packet.
- Reset mid-operation: immediate return to IDLE and all outputs 0. The next packet requires a new load.

Test Plan:
- DLEN=6, REPEATS=1, payload 48'h665544332211, load, frame_start, then 3 pixel_req -> pixel_value sequence:
  - 7E7E7E7E7E7E, C0DE00000006, 665544332211, 665544332211.
  - done pulses once; busy then falls.
- DLEN=7, payload 56'h77665544332211 -> data words 665544332211 and 000000000077; checksum 665544332266; header C0DE00000007.
- DLEN=6, REPEATS=2, pixel_req toggling every other cycle -> the full packet is sent in each of two frames. WAIT_FRAME outputs 0 between them. done fires only after the second frame.
- frame_start asserted after W2 of DLEN=12 -> the next word is W0 again; the checksum of the restarted packet is correct; the repeat count is not incremented.
- load asserted while busy with a different payload -> the transmitted payload is unchanged. load and frame_start in the same cycle from IDLE -> transmission starts only on the next frame_start.
- rst pulsed mid-SEND -> busy=0 and pixel_value=0 immediately (asynchronously). Subsequent pixel_req and frame_start produce no words until a new load.
